// File: rtl/fuse_ctrl_pkg.sv
// fuse_ctrl_pkg: shared definitions for the fuse controller.
//   - default parameter values for fuse_ctrl and fuse_rom
//   - fuse_state_e, the controller FSM state encoding
//   - FUSE_IMAGE, the constant fuse contents. The last word holds the
//     additive checksum (modulo 2^WORD_W) of all other words.
package fuse_ctrl_pkg;

    localparam int unsigned DEF_WORD_W    = 32;
    localparam int unsigned DEF_NUM_WORDS = 100;
    localparam int unsigned DEF_NUM_CH    = 3;
    localparam int unsigned DEF_CH_WORDS  = 8;
    localparam int unsigned DEF_SEC_LO    = 0;
    localparam int unsigned DEF_SEC_HI    = 56;
    localparam int unsigned DEF_CH_BASE [DEF_NUM_CH] = '{73, 65, 57};

    // Fixed encodings so existing debug tooling keeps decoding the state.
    localparam logic [1:0] ST_LOAD_ENC  = 2'd0;
    localparam logic [1:0] ST_CHECK_ENC = 2'd1;
    localparam logic [1:0] ST_READY_ENC = 2'd2;
    localparam logic [1:0] ST_ERROR_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_LOAD  = ST_LOAD_ENC,
        ST_CHECK = ST_CHECK_ENC,
        ST_READY = ST_READY_ENC,
        ST_ERROR = ST_ERROR_ENC
    } fuse_state_e;

    typedef logic [DEF_NUM_WORDS-1:0][DEF_WORD_W-1:0] fuse_image_t;

    // Builds the image: pseudo-random payload words plus a trailing checksum.
    function automatic fuse_image_t gen_fuse_image();
        fuse_image_t             img;
        logic [DEF_WORD_W-1:0]   sum;
        img = '0;
        sum = '0;
        for (int i = 0; i < int'(DEF_NUM_WORDS) - 1; i++) begin
            img[i] = (32'h9E37_79B9 * 32'(i + 1)) ^ {8'(i), 24'h5A_A5C3};
            sum    = sum + img[i];
        end
        img[DEF_NUM_WORDS-1] = sum;
        return img;
    endfunction

    localparam fuse_image_t FUSE_IMAGE = gen_fuse_image();

endpackage

// File: rtl/fuse_rom.sv
// fuse_rom: synchronous-read fuse ROM, 1-cycle latency.
// This is the only holder of fuse contents ahead of the shadow copy.
//   clk_i  - clock
//   en     - read enable; rdata updates on the next edge when set
//   addr   - word index
//   rdata  - word at addr, valid the cycle after the read was issued
module fuse_rom
    import fuse_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
    parameter int unsigned IDX_W     = $clog2(NUM_WORDS),
    parameter logic [NUM_WORDS-1:0][WORD_W-1:0] IMAGE = FUSE_IMAGE
) (
    input  logic              clk_i,
    input  logic              en,
    input  logic [IDX_W-1:0]  addr,
    output logic [WORD_W-1:0] rdata
);

    always_ff @(posedge clk_i) begin
        if (en) begin
            rdata <= IMAGE[addr];
        end
    end

endmodule

// File: rtl/fuse_ctrl.sv
// fuse_ctrl: fuse controller. Copies the fuse image from fuse_rom into
// shadow registers after reset, optionally integrity-checks it, then serves
// word reads and drives the hash/key channels.
// Optional feature macro: FUSE_CTRL_CHECKSUM_EN (checksum check + ERROR state).
// Ports:
//   clk_i, rst_ni      - clock, synchronous active-low reset
//   req_i, addr_i      - read request, word index (full 32-bit compare)
//   gnt_o              - request accepted this cycle
//   rvalid_o, rdata_o, err_o - read response one cycle after grant
//   lock_i, locked_o   - sticky lock of the secret window
//   ready_o            - shadow loaded (and checked, when enabled)
//   fuse_err_o         - checksum mismatch, sticky until reset
//   hash_o             - NUM_CH channels of CH_WORDS words each
module fuse_ctrl
    import fuse_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
    parameter int unsigned NUM_CH    = DEF_NUM_CH,
    parameter int unsigned CH_WORDS  = DEF_CH_WORDS,
    parameter int unsigned CH_BASE [NUM_CH] = DEF_CH_BASE,
    parameter int unsigned SEC_LO    = DEF_SEC_LO,
    parameter int unsigned SEC_HI    = DEF_SEC_HI,
    parameter logic [NUM_WORDS-1:0][WORD_W-1:0] IMAGE = FUSE_IMAGE
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                req_i,
    input  logic [31:0]                         addr_i,
    output logic                                gnt_o,
    output logic                                rvalid_o,
    output logic [WORD_W-1:0]                   rdata_o,
    output logic                                err_o,
    input  logic                                lock_i,
    output logic                                locked_o,
    output logic                                ready_o,
    output logic                                fuse_err_o,
    output logic [NUM_CH*CH_WORDS*WORD_W-1:0]   hash_o
);

    localparam int unsigned IDX_W = $clog2(NUM_WORDS);
    localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
    localparam int unsigned CH_W  = CH_WORDS * WORD_W;

    fuse_state_e       state_q;
    logic [CNT_W-1:0]  rom_addr_q;
    logic              cap_vld_q;
    logic [IDX_W-1:0]  cap_idx_q;
    logic [WORD_W-1:0] rom_rdata;
    logic [WORD_W-1:0] shadow_q [NUM_WORDS];
    logic              issue;
    logic              last_cap;

    // ROM reads are issued while the counter has not passed the last word;
    // the data comes back one cycle later and is tagged by cap_idx_q.
    assign issue    = (state_q == ST_LOAD) && (rom_addr_q < CNT_W'(NUM_WORDS));
    assign last_cap = cap_vld_q && (cap_idx_q == IDX_W'(NUM_WORDS - 1));

    fuse_rom #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W),
        .IMAGE     (IMAGE)
    ) u_rom (
        .clk_i (clk_i),
        .en    (issue),
        .addr  (rom_addr_q[IDX_W-1:0]),
        .rdata (rom_rdata)
    );

`ifdef FUSE_CTRL_CHECKSUM_EN
    logic [WORD_W-1:0] acc_q;

    // The last word is the stored checksum, so it is not summed.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (cap_vld_q && !last_cap) begin
            acc_q <= acc_q + rom_rdata;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_LOAD;
            rom_addr_q <= '0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= '0;
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            cap_vld_q <= issue;
            cap_idx_q <= rom_addr_q[IDX_W-1:0];
            if (issue) begin
                rom_addr_q <= rom_addr_q + 1'b1;
            end
            if (cap_vld_q) begin
                shadow_q[cap_idx_q] <= rom_rdata;
            end
            case (state_q)
                ST_LOAD: begin
                    if (last_cap) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
`ifdef FUSE_CTRL_CHECKSUM_EN
                    state_q <= (acc_q == shadow_q[NUM_WORDS-1]) ? ST_READY : ST_ERROR;
`else
                    state_q <= ST_READY;
`endif
                end
                default: state_q <= state_q;  // READY and ERROR hold until reset
            endcase
        end
    end

    assign ready_o = (state_q == ST_READY);
`ifdef FUSE_CTRL_CHECKSUM_EN
    assign fuse_err_o = (state_q == ST_ERROR);
`else
    assign fuse_err_o = 1'b0;
`endif

    // Read handshake: a request is accepted in the cycle where req_i and
    // gnt_o are both high; gnt_o is only ever high in READY and needs no
    // back-pressure from the requester. Every accepted request produces
    // exactly one rvalid_o pulse on the following cycle, carrying rdata_o
    // and err_o; rdata_o/err_o are zero whenever rvalid_o is low.
    logic              in_range;
    logic [31:0]       sec_off;
    logic              sec_hit;
    logic              blocked;
    logic              locked_q;
    logic              rvalid_q;
    logic              err_q;
    logic [WORD_W-1:0] rdata_q;

    assign gnt_o    = req_i && (state_q == ST_READY);
    assign in_range = addr_i < 32'(NUM_WORDS);
    // Offset compare covers both window bounds; addresses below SEC_LO wrap
    // to large values and fall outside.
    assign sec_off  = addr_i - 32'(SEC_LO);
    assign sec_hit  = sec_off <= 32'(SEC_HI - SEC_LO);
    // A lock arriving with the request already hides the window.
    assign blocked  = !in_range || (sec_hit && (locked_q || lock_i));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            locked_q <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            locked_q <= locked_q | lock_i;
            rvalid_q <= gnt_o;
            if (gnt_o) begin
                err_q   <= blocked;
                rdata_q <= blocked ? '0 : shadow_q[addr_i[IDX_W-1:0]];
            end else begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    assign locked_o = locked_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

    // Channel c: word CH_BASE[c] in the LSW up to CH_BASE[c]+CH_WORDS-1.
    for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
        for (genvar w = 0; w < int'(CH_WORDS); w++) begin : g_word
            assign hash_o[c*CH_W + w*WORD_W +: WORD_W] =
                ready_o ? shadow_q[CH_BASE[c] + w] : '0;
        end
    end

endmodule

// File: tb/tb_fuse_ctrl.sv
module tb_fuse_ctrl;
    import fuse_ctrl_pkg::*;

    localparam int CHK_W = 768;
    localparam fuse_image_t BAD_IMAGE = FUSE_IMAGE ^ (fuse_image_t'(1) << (3 * DEF_WORD_W));

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic         req, lock, gnt, rvalid, err, locked, ready, fuse_err;
    logic [31:0]  addr, rdata;
    logic [767:0] hash;

    logic         req_b, gnt_b, rvalid_b, err_b, locked_b, ready_b, fuse_err_b;
    logic [31:0]  rdata_b;
    logic [767:0] hash_b;

    fuse_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt),
        .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .lock_i(lock),
        .locked_o(locked), .ready_o(ready), .fuse_err_o(fuse_err), .hash_o(hash)
    );

    fuse_ctrl #(.IMAGE(BAD_IMAGE)) dut_bad (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .addr_i(32'd0), .gnt_o(gnt_b),
        .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b), .lock_i(1'b0),
        .locked_o(locked_b), .ready_o(ready_b), .fuse_err_o(fuse_err_b), .hash_o(hash_b)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [32:0] exp_q[$];  // {err, rdata}

    task automatic check(input string tag, input logic [CHK_W-1:0] got, input logic [CHK_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CHK_W-1:0] exp_hash(input fuse_image_t img);
        int unsigned base [3] = '{73, 65, 57};
        logic [CHK_W-1:0] h;
        h = '0;
        for (int c = 0; c < 3; c++)
            for (int w = 0; w < 8; w++)
                h[(c*8 + w)*32 +: 32] = img[base[c] + w];
        return h;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request cycle and check the grant; accepted requests queue
    // their expected response.
    task automatic send(input logic r, input logic [31:0] a, input logic l,
                        input logic exp_gnt, input logic [31:0] d, input logic e);
        req  = r;
        addr = a;
        lock = l;
        #1;
        check($sformatf("gnt@%0h", a), gnt, exp_gnt);
        if (exp_gnt) exp_q.push_back({e, d});
    endtask

    task automatic rsp(input string tag);
        logic [32:0] x;
        check({tag, "_rvalid"}, rvalid, 1'b1);
        check({tag, "_qsize"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check({tag, "_rdata"}, rdata, x[31:0]);
            check({tag, "_err"}, err, x[32]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; req = 1'b1; addr = '0; lock = 1'b0; req_b = 1'b0;
        step();
        step();
        check("rst_ready", ready, 1'b0);
        check("rst_gnt", gnt, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_locked", locked, 1'b0);
        check("rst_fuse_err", fuse_err, 1'b0);
        check("rst_hash", hash, '0);
        req = 1'b0;

        rst_n = 1'b1;                 // cycle 0
        repeat (101) step();          // cycle 101 (CHECK)
        check("c101_ready", ready, 1'b0);
        check("c101_hash", hash, '0);
        check("c101_bad_err", fuse_err_b, 1'b0);
        check("c101_bad_ready", ready_b, 1'b0);
        req_b = 1'b1;
        step();                       // cycle 102
        check("c102_ready", ready, 1'b1);
        check("c102_fuse_err", fuse_err, 1'b0);
        check("c102_hash_ch0", hash[255:0], {FUSE_IMAGE[80], FUSE_IMAGE[79], FUSE_IMAGE[78],
              FUSE_IMAGE[77], FUSE_IMAGE[76], FUSE_IMAGE[75], FUSE_IMAGE[74], FUSE_IMAGE[73]});
        check("c102_hash_all", hash, exp_hash(FUSE_IMAGE));
`ifdef FUSE_CTRL_CHECKSUM_EN
        check("bad_fuse_err", fuse_err_b, 1'b1);
        check("bad_ready", ready_b, 1'b0);
        check("bad_hash", hash_b, '0);
        check("bad_gnt", gnt_b, 1'b0);
`else
        check("bad_fuse_err", fuse_err_b, 1'b0);
        check("bad_ready", ready_b, 1'b1);
        check("bad_hash", hash_b, exp_hash(BAD_IMAGE));
        check("bad_gnt", gnt_b, 1'b1);
`endif
        check("bad_rvalid", rvalid_b, 1'b0);
        check("bad_rdata", rdata_b, 32'd0);
        check("bad_err", err_b, 1'b0);
        check("bad_locked", locked_b, 1'b0);
        req_b = 1'b0;

        // Reads in READY, back to back.
        send(1, 32'd5, 0, 1, FUSE_IMAGE[5], 0);            step();
        rsp("a5");   send(1, 32'd99, 0, 1, FUSE_IMAGE[99], 0); step();
        rsp("a99");  send(1, 32'd100, 0, 1, 32'd0, 1);     step();
        rsp("a100"); send(1, 32'h8000_0005, 0, 1, 32'd0, 1); step();
        rsp("ahi");  send(1, 32'd40, 0, 1, FUSE_IMAGE[40], 0); step();
        rsp("a40");
        check("pre_lock", locked, 1'b0);
        send(1, 32'd40, 1, 1, 32'd0, 1);                    step();
        rsp("a40lk");
        check("post_lock", locked, 1'b1);
        send(1, 32'd57, 0, 1, FUSE_IMAGE[57], 0);           step();
        rsp("a57");  send(1, 32'd56, 1, 1, 32'd0, 1);       step();
        rsp("a56");  send(1, 32'd0, 0, 1, 32'd0, 1);        step();
        rsp("a0");   send(0, 32'd3, 0, 0, 32'd0, 0);        step();
        check("idle_rvalid", rvalid, 1'b0);
        check("idle_rdata", rdata, 32'd0);
        check("lock_sticky", locked, 1'b1);

        // Reset with a response pending drops it.
        send(1, 32'd5, 0, 1, FUSE_IMAGE[5], 0);
        rst_n = 1'b0;
        step();
        exp_q.delete();
        check("drop_rvalid", rvalid, 1'b0);
        check("drop_locked", locked, 1'b0);
        check("drop_ready", ready, 1'b0);
        req = 1'b0;

        // Request during LOAD, lock during LOAD, reset mid-load.
        rst_n = 1'b1;                 // cycle 0
        repeat (50) step();           // cycle 50
        send(1, 32'd5, 0, 0, 32'd0, 0); step();   // cycle 51
        check("load_rvalid", rvalid, 1'b0);
        send(0, 32'd0, 1, 0, 32'd0, 0); step();   // cycle 52
        lock = 1'b0;
        check("load_locked", locked, 1'b1);
        repeat (8) step();            // cycle 60
        rst_n = 1'b0;
        step();
        check("mid_rst_locked", locked, 1'b0);
        check("mid_rst_ready", ready, 1'b0);
        rst_n = 1'b1;                 // cycle 0
        repeat (101) step();
        check("re_c101_ready", ready, 1'b0);
        step();
        check("re_c102_ready", ready, 1'b1);
        check("re_c102_locked", locked, 1'b0);
        check("re_c102_hash", hash, exp_hash(FUSE_IMAGE));
        send(1, 32'd99, 0, 1, FUSE_IMAGE[99], 0); step();
        rsp("re_a99");
        send(1, 32'd20, 0, 1, FUSE_IMAGE[20], 0); step();
        rsp("re_a20");
        req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fuse_ctrl.md
# fuse_ctrl

Parametrised fuse controller that supersedes the flat constant fuse memory. After reset it copies the fuse image word by word from a 1-cycle-latency fuse ROM into shadow registers, then integrity-checks it. It then serves word reads on the peripheral bus, with a sticky lock that hides a secret window. It drives N fixed-width hash/key channels directly to consumers such as the JTAG unlock and HMAC blocks.

## Interface
- WORD_W, 32, fuse word width in bits.
- NUM_WORDS, 100, fuse words; must be ≥ 2.
- NUM_CH, 3, number of hash/key output channels.
- CH_WORDS, 8, words per channel.
- CH_BASE, '{73,65,57}, per-channel base word index. Channel c = words CH_BASE[c]+CH_WORDS-1 (MSW) down to CH_BASE[c] (LSW).
- SEC_LO / SEC_HI, 0 / 56, inclusive word-index range of the secret window.
- clk_i input 1 — single clock; all logic on its rising edge.
- rst_ni input 1 — synchronous, active-low reset.
- req_i input 1 — read request.
- addr_i input 32 — word index; not a byte address.
- gnt_o output 1 — request accepted this cycle.
- rvalid_o output 1 — read response valid.
- rdata_o output WORD_W — read data.
- err_o output 1 — response error; qualifies rvalid_o.
- lock_i input 1 — lock request pulse.
- locked_o output 1 — secret window locked.
- ready_o output 1 — shadow loaded and, if enabled, checked OK.
- fuse_err_o output 1 — checksum mismatch, sticky until reset.
- hash_o output NUM_CH×(CH_WORDS·WORD_W) — channel data.

## Operation
- FSM states: LOAD → CHECK → READY, or LOAD → CHECK → ERROR. Reset forces LOAD, clears all shadow words, clears the lock, and zeroes the checksum accumulator.
- LOAD:
  - ROM address counter runs 0..NUM_WORDS-1, one per cycle.
  - The word is captured into shadow[k] one cycle after address k is issued.
  - Each captured word except the last is added modulo 2^WORD_W to the accumulator.
  - Ends when word NUM_WORDS-1 is captured.
- CHECK: a single cycle that compares the accumulator with shadow[NUM_WORDS-1].
  - Match → READY.
  - Mismatch → ERROR.
- READY is terminal until reset. ERROR is terminal until reset; fuse_err_o=1 in ERROR.
- Read port:
  - gnt_o = req_i only in READY; it is 0 in LOAD, CHECK and ERROR.
  - Each granted request gives exactly one response, one cycle later. Back-to-back requests every cycle are allowed.
  - Response rules:
    - addr_i ≥ NUM_WORDS → rdata_o=0, err_o=1.
    - SEC_LO ≤ addr_i ≤ SEC_HI and (locked_o | lock_i) → rdata_o=0, err_o=1. A lock asserted in the same cycle as a request blocks that request.
    - Otherwise → rdata_o=shadow[addr_i], err_o=0.
  - addr_i is compared at full 32-bit width; there is no truncation aliasing.
- Lock:
  - lock_i sets locked_o on the next edge in any state. The lock stays set until reset.
  - Repeated lock_i pulses have no further effect.
- hash_o: channel data from shadow only in READY; all zero otherwise.

## Timing
- All outputs reset to 0. rdata_o is held at 0 when rvalid_o=0.
- Cycle 0 is the first cycle with rst_ni=1.
  - LOAD spans cycles 0..NUM_WORDS.
  - CHECK is cycle NUM_WORDS+1.
  - ready_o and hash_o become valid from cycle NUM_WORDS+2; for the defaults, cycle 102.
- fuse_err_o rises in the same cycle ERROR is entered.
- Read latency is 1 cycle from grant to rvalid_o.
- rst_ni=0 at any point, including mid-LOAD or with a response pending:
  - Takes effect at the next edge.
  - The pending response is dropped (rvalid_o=0).
  - The load restarts from word 0.

## Configuration
- FUSE_CTRL_CHECKSUM_EN defined:
  - CHECK performs the comparison; a mismatch enters ERROR, keeps hash_o at 0, and withholds grants.
- Not defined:
  - No accumulator is built.
  - CHECK always goes to READY.
  - fuse_err_o is tied to 0.
  - The last word is readable like any other.

## Structure
- fuse_ctrl_pkg holds:
  - the FSM state enum (fuse_state_e);
  - default parameter values;
  - FUSE_IMAGE, the NUM_WORDS×WORD_W constant fuse contents. Its last word is the additive checksum of all other words.
- Sub-module fuse_rom:
  - synchronous read, 1-cycle latency, content taken from FUSE_IMAGE;
  - it is the only place fuse contents exist before the shadow copy.

## Test plan
- Reset release with the default image → ready_o=1 exactly at cycle 102; fuse_err_o=0; hash_o[0] equals image words 80..73 concatenated, word 80 in the MSW.
- In READY, read addr 5, then addr 99 back-to-back → two consecutive rvalid_o responses with image[5] and image[99], err_o=0; then addr 100 and addr 0x8000_0005 → err_o=1, rdata_o=0.
- Read addr 40 → image[40]. Pulse lock_i together with a read of addr 40 → err_o=1, rdata 0. Then locked_o=1; addr 57 still returns image[57].
- Request during LOAD at cycle 50 → gnt_o=0 and no rvalid_o. Assert rst_ni=0 at cycle 60 → load restarts; ready_o rises 102 cycles after release; locked_o=0.
- With FUSE_CTRL_CHECKSUM_EN, flip bit 0 of image[3] → ERROR at cycle 102: fuse_err_o=1, ready_o=0, hash_o=0, gnt_o=0. Without the macro, the same image → ready_o=1.
